// File: rtl/iddmm_pkg.sv
// Shared types and constants for the interleaved Montgomery multiplier controller.
package iddmm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } iddmm_state_t;

  // Read-to-write-back latency of the word datapath.
  localparam int IDDMM_PIPE_LAT = 28;

endpackage

// File: rtl/iddmm_ctrl.sv
// Outer/inner word-loop sequencer: issues N+1 word reads per outer iteration, then waits for N write-backs.
// Optional abort input when IDDMM_CTRL_ABORT_EN is defined.
module iddmm_ctrl
  import iddmm_pkg::*;
#(
  parameter int K      = 128,
  parameter int N      = 32,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef IDDMM_CTRL_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] y_rd_addr,
  output logic [ADDR_W:0]   j_cnt,
  input  logic              wr_a_en
);

  localparam logic [ADDR_W:0]   J_LAST  = (ADDR_W+1)'(N);
  localparam logic [ADDR_W:0]   WB_LAST = (ADDR_W+1)'(N - 1);
  localparam logic [ADDR_W:0]   WB_MAX  = (ADDR_W+1)'(N);
  localparam logic [ADDR_W-1:0] I_LAST  = ADDR_W'(N - 1);

  generate
    if (K < 1 || N < 2) begin : g_bad_param
      $error("iddmm_ctrl: K must be >= 1 and N >= 2");
    end
  endgenerate

  iddmm_state_t      state;
  logic [ADDR_W-1:0] i;
  logic [ADDR_W:0]   j;
  logic [ADDR_W:0]   wb_cnt;
  logic [ADDR_W:0]   j_nxt;

  assign j_nxt = j + (ADDR_W+1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      y_rd_addr <= '0;
      j_cnt     <= '0;
      i         <= '0;
      j         <= '0;
      wb_cnt    <= '0;
    end else
`ifdef IDDMM_CTRL_ABORT_EN
    if (abort) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      y_rd_addr <= '0;
      j_cnt     <= '0;
      i         <= '0;
      j         <= '0;
      wb_cnt    <= '0;
    end else
`endif
    begin
      // j_cnt lines up with RAM read data one cycle after the issue.
      j_cnt <= (state == ISSUE) ? j : '0;
      if (busy && wr_a_en && wb_cnt != WB_MAX)
        wb_cnt <= wb_cnt + (ADDR_W+1)'(1);

      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            rd_en     <= 1'b1;
            rd_addr   <= '0;
            y_rd_addr <= '0;
            i         <= '0;
            j         <= '0;
            wb_cnt    <= '0;
          end
        end
        ISSUE: begin
          if (j == J_LAST) begin
            state   <= DRAIN;
            rd_en   <= 1'b0;
            rd_addr <= '0;
          end else begin
            j       <= j_nxt;
            rd_addr <= (j_nxt == J_LAST) ? '0 : j_nxt[ADDR_W-1:0];
          end
        end
        DRAIN: begin
          if (wr_a_en && wb_cnt == WB_LAST) begin
            if (i != I_LAST) begin
              state     <= ISSUE;
              rd_en     <= 1'b1;
              rd_addr   <= '0;
              y_rd_addr <= i + ADDR_W'(1);
              i         <= i + ADDR_W'(1);
              j         <= '0;
              wb_cnt    <= '0;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          done   <= 1'b0;
          i      <= '0;
          j      <= '0;
          wb_cnt <= '0;
        end
      endcase
    end
  end

endmodule
